// File: rtl/shift_sequencer_if.sv
// Shift sequencer request/response bundle.
//   master : issues start/flush and the operand fields, observes ready/busy/done
//            and the result/carry.
//   slave  : the sequencer itself.
// Signals:
//   start, flush, imm_mode, shift_type[1:0], operand[DATA_W-1:0], amount[4:0],
//   imm12[11:0], c_in    -> request side
//   ready, busy, done, result[DATA_W-1:0], c_out -> response side
interface shift_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              flush;
  logic              imm_mode;
  logic [1:0]        shift_type;
  logic [DATA_W-1:0] operand;
  logic [4:0]        amount;
  logic [11:0]       imm12;
  logic              c_in;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              c_out;

  modport master (
    output start, flush, imm_mode, shift_type, operand, amount, imm12, c_in,
    input  ready, busy, done, result, c_out
  );

  modport slave (
    input  start, flush, imm_mode, shift_type, operand, amount, imm12, c_in,
    output ready, busy, done, result, c_out
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter for the EXE-stage operand path. Moves at most STEP bit
// positions per cycle for LSL/LSR/ASR/ROR by register amount, or rotates an
// 8-bit immediate right by 2*rot.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : shift_sequencer_if.slave (start/flush/operand fields in,
//            ready/busy/done/result/c_out out)
// Flow: IDLE -(start)-> SHIFT (ceil(rem/STEP) cycles) -> DONE (1 cycle) -> IDLE.
// Zero shift goes straight IDLE -> DONE. flush returns to IDLE from any state
// without touching result/c_out.
module shift_sequencer #(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] val_q, result_q;
  logic [1:0]        typ_q;
  logic [5:0]        rem_q;
  logic              sign_q, carry_q, cout_q;

  // capture selection
  logic [DATA_W-1:0] cap_val;
  logic [1:0]        cap_typ;
  logic [5:0]        cap_rem;
  logic              accept;

  always_comb begin
    if (bus.imm_mode) begin
      cap_val = {{(DATA_W-8){1'b0}}, bus.imm12[7:0]};
      cap_typ = T_ROR;
      cap_rem = {1'b0, bus.imm12[11:8], 1'b0};
    end else begin
      cap_val = bus.operand;
      cap_typ = bus.shift_type;
      cap_rem = {1'b0, bus.amount};
    end
  end

  assign accept = (state_q == IDLE) && bus.start && !bus.flush;

  // one SHIFT cycle: k = min(rem, STEP) single-bit moves, unrolled
  logic [5:0]        k;
  logic [5:0]        rem_nxt;
  logic [DATA_W-1:0] val_step;
  logic              carry_step;

  always_comb begin
    k          = (rem_q > 6'(STEP)) ? 6'(STEP) : rem_q;
    val_step   = val_q;
    carry_step = carry_q;
    for (int i = 0; i < STEP; i++) begin
      if (6'(i) < k) begin
        case (typ_q)
          T_LSL: begin
            carry_step = val_step[DATA_W-1];
            val_step   = {val_step[DATA_W-2:0], 1'b0};
          end
          T_LSR: begin
            carry_step = val_step[0];
            val_step   = {1'b0, val_step[DATA_W-1:1]};
          end
          T_ASR: begin
            carry_step = val_step[0];
            val_step   = {sign_q, val_step[DATA_W-1:1]};
          end
          default: begin
            val_step   = {val_step[0], val_step[DATA_W-1:1]};
            carry_step = val_step[DATA_W-1];
          end
        endcase
      end
    end
    rem_nxt = rem_q - k;
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = (cap_rem == 6'd0) ? DONE : SHIFT;
        SHIFT:   if (rem_nxt == 6'd0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // datapath; result/c_out load only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= '0;
      typ_q    <= T_LSL;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      val_q   <= cap_val;
      typ_q   <= cap_typ;
      rem_q   <= cap_rem;
      sign_q  <= cap_val[DATA_W-1];
      carry_q <= bus.c_in;
      if (cap_rem == 6'd0) begin
        result_q <= cap_val;
        cout_q   <= bus.c_in;
      end
    end else if (state_q == SHIFT && !bus.flush) begin
      val_q   <= val_step;
      rem_q   <= rem_nxt;
      carry_q <= carry_step;
      if (rem_nxt == 6'd0) begin
        result_q <= val_step;
        cout_q   <= carry_step;
      end
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.c_out  = cout_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the EXE-stage shift operand path.
- Performs register-specified shifts (LSL/LSR/ASR/ROR) and immediate rotates (8-bit value rotated right by 2*rot).
- Applies at most STEP bit positions per cycle; runs under a start/ready/done handshake.
- Replaces the single-cycle 32-bit barrel shift on timing-critical builds; sits between ID/EXE register outputs and ALU Val2 input; the hazard unit stalls on busy.

Parameters:
- DATA_W, 32, operand/result width; only 32 supported.
- STEP, 4, max bit positions shifted per cycle; power of two, 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- flush  input  1  abort current operation (pipeline flush)
- imm_mode  input  1  1: use imm12 rotate; 0: use operand/shift_type/amount
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- operand  input  32  Rm value
- amount  input  5  shift amount 0..31
- imm12  input  12  [11:8] rot, [7:0] value
- c_in  input  1  current C flag
- ready  output  1  idle, can accept start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result/c_out valid
- result  output  32  shifted value, held until next accepted start
- c_out  output  1  shifter carry-out

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; result=0, c_out=0, done=0, busy=0, ready=1.
  - Reset mid-operation aborts immediately; no done is produced.
- States: IDLE, SHIFT, DONE.
  - ready=1 only in IDLE; busy=1 only in SHIFT; done=1 only in DONE.
- IDLE, start=1, flush=0 at an edge: capture working registers.
  - imm_mode=1: value={24'b0,imm12[7:0]}, type=ROR, rem=2*imm12[11:8] (6-bit, 0..30).
  - imm_mode=0: value=operand, type=shift_type, rem=amount.
  - rem!=0 -> SHIFT; rem==0 -> DONE with result=value, c_out=c_in.
  - Inputs are not re-sampled after capture.
- SHIFT, each edge:
  - k=min(rem,STEP); value shifted by k per type; rem-=k.
  - LSL: zero fill; carry = last bit shifted out of bit 31.
  - LSR: zero fill; carry = last bit out of bit 0.
  - ASR: fill with bit 31 of captured value; carry = last bit out of bit 0.
  - ROR: rotate; carry = new bit 31.
  - Carry register updates every SHIFT cycle; final c_out = carry of the last bit position moved.
  - rem reaches 0 -> DONE, result/c_out loaded.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
  - A start is not accepted in DONE (ready=0).
- Latency: done visible after ceil(rem/STEP)+1 edges from the accepting edge; amount 0 gives 1 edge.
- Back-to-back throughput: one op per ceil(rem/STEP)+2 cycles.
- Amount 0 in register mode means no shift for all types (no ARM LSR/ASR #32 or RRX encoding).
- start while busy or in DONE: ignored, not queued.
- flush=1 in any state at an edge:
  - Next state IDLE; done not asserted; result and c_out unchanged.
  - flush wins over a simultaneous start.
- result and c_out change only on entry to DONE or reset; stable at all other times.

Test Plan:
- LSL, operand=0x0000_0001, amount=31, STEP=4 -> busy high 8 cycles; done on 9th edge; result=0x8000_0000, c_out=0.
- ASR, operand=0x8000_0000, amount=4 -> one SHIFT cycle; done on 2nd edge; result=0xF800_0000, c_out=0. Repeat with LSR -> 0x0800_0000.
- ROR, operand=0x0000_00F1, amount=5 -> result=0x8800_0007, c_out=1. Then imm_mode=1, imm12=0x4FF -> 2 SHIFT cycles; result=0xFF00_0000, c_out=1.
- LSR, amount=0, c_in=1, operand=0x1234_5678 -> done on 1st edge; result=0x1234_5678, c_out=1. Second start during the done cycle -> ignored.
- LSL by 31 in progress:
  - Assert start with different data mid-op -> ignored; original result delivered.
  - flush on 3rd SHIFT cycle -> IDLE next edge; no done; result keeps prior value.
- Reset mid-SHIFT (rst_n low between edges) -> outputs immediately 0, ready=1. After release, a new op completes correctly.
